// File: rtl/calc_pkg.sv
// Shared definitions for the calculator datapath.
//   state_t     : controller states for the sequential divider
//   CALC_WIDTH  : default operand width of the calculator (4-bit x/y)
//   TRIAL_W     : width the trial-subtract helper works at. It supports any
//                 operand width up to TRIAL_W-1 (32 bits).
//   trial_sub   : unsigned subtract used for the restoring trial. Operands are
//                 zero-extended by the caller. A borrow shows up as ones in
//                 every bit above the operand width.
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CALC_WIDTH = 4;
  localparam int TRIAL_W    = 33;

  function automatic logic [TRIAL_W-1:0] trial_sub(input logic [TRIAL_W-1:0] a,
                                                   input logic [TRIAL_W-1:0] b);
    return a - b;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step, purely combinational.
//   rem     in  WIDTH  partial remainder (always < y)
//   q       in  WIDTH  quotient shift register; the MSB is the next dividend bit
//   y       in  WIDTH  divisor (non-zero)
//   rem_nxt out WIDTH  partial remainder after this step
//   q_nxt   out WIDTH  q shifted left, with the new quotient bit in the LSB
// WIDTH must be between 2 and 32.
module div_step
  import calc_pkg::*;
#(
  parameter int WIDTH = CALC_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] rem_nxt,
  output logic [WIDTH-1:0] q_nxt
);

  logic [WIDTH:0]     shifted;
  logic [TRIAL_W-1:0] trial;
  logic               neg;

  // {rem,q} << 1: the remainder picks up the dividend bit leaving q.
  assign shifted = {rem, q[WIDTH-1]};
  assign trial   = trial_sub(TRIAL_W'(shifted), TRIAL_W'(y));

  // A non-negative trial is < y, so every bit from WIDTH upward is zero.
  // A borrow sets all of them.
  assign neg = |trial[TRIAL_W-1:WIDTH];

  // When the trial is negative, shifted < y < 2^WIDTH, so dropping its MSB is safe.
  assign rem_nxt = neg ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  assign q_nxt   = {q[WIDTH-2:0], ~neg};

endmodule

// File: rtl/div_seq.sv
// Multi-cycle restoring divider for the calculator datapath.
// It accepts one x/y pair per input handshake and runs one shift-subtract
// step per clock. It returns quotient, remainder and a divide-by-zero flag
// through an output handshake.
//   clk, rst          clock; synchronous active-high reset
//   in_valid/in_ready input handshake; in_ready is high only in IDLE
//   x, y              dividend/divisor, sampled only on accept
//   out_valid/out_ready result handshake; the result is held while out_ready is low
//   quotient, remainder, div_by_zero  registered result
//   busy              high whenever the controller is not IDLE
// Build option: define DIV_SEQ_SIGNED_EN for two's-complement operands.
// The quotient then truncates toward zero and the remainder takes the
// dividend's sign.
module div_seq
  import calc_pkg::*;
#(
  parameter int WIDTH = CALC_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH - 1);

  state_t           state, state_nxt;
  logic             accept, last;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem_r, q_r, y_r;
  logic [WIDTH-1:0] rem_step, q_step;
  logic [WIDTH-1:0] x_mag, y_mag, q_fin, r_fin;

  assign accept = in_valid & in_ready;
  assign last   = (cnt == '0);

`ifdef DIV_SEQ_SIGNED_EN
  logic sx, sq;

  // The most-negative value maps onto itself. Read as unsigned, that is the
  // correct magnitude, so the -8 / -1 overflow comes out as 1000 with no flag.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  assign x_mag = mag(x);
  assign y_mag = mag(y);
  assign q_fin = apply_sign(q_step, sq);
  assign r_fin = apply_sign(rem_step, sx);
`else
  assign x_mag = x;
  assign y_mag = y;
  assign q_fin = q_step;
  assign r_fin = rem_step;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem_r),
    .q       (q_r),
    .y       (y_r),
    .rem_nxt (rem_step),
    .q_nxt   (q_step)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (y == '0) ? DONE : ITER;
      ITER:    if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from the state register
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_r       <= '0;
      q_r         <= '0;
      y_r         <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef DIV_SEQ_SIGNED_EN
      sx          <= 1'b0;
      sq          <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (y == '0) begin
              // The divider loop is skipped; remainder carries the raw dividend.
              quotient    <= '1;
              remainder   <= x;
              div_by_zero <= 1'b1;
            end else begin
              rem_r       <= '0;
              q_r         <= x_mag;
              y_r         <= y_mag;
              cnt         <= CNT_INIT;
              div_by_zero <= 1'b0;
`ifdef DIV_SEQ_SIGNED_EN
              sx          <= x[WIDTH-1];
              sq          <= x[WIDTH-1] ^ y[WIDTH-1];
`endif
            end
          end
        end
        ITER: begin
          rem_r <= rem_step;
          q_r   <= q_step;
          cnt   <= cnt - 1'b1;
          if (last) begin
            quotient  <= q_fin;
            remainder <= r_fin;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
module tb_div_seq;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready;
  logic [W-1:0] x, y;
  logic         out_valid, out_ready;
  logic [W-1:0] quotient, remainder;
  logic         div_by_zero, busy;

  int tests  = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .x           (x),
    .y           (y),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division on the operand values
  task automatic model(input logic [W-1:0] xa, input logic [W-1:0] ya,
                       output logic [W-1:0] eq, output logic [W-1:0] er, output logic ed);
    int xs, ys;
`ifdef DIV_SEQ_SIGNED_EN
    xs = int'($signed(xa));
    ys = int'($signed(ya));
`else
    xs = int'(xa);
    ys = int'(ya);
`endif
    if (ys == 0) begin
      eq = '1;
      er = xa;
      ed = 1'b1;
    end else begin
      eq = W'(xs / ys);
      er = W'(xs % ys);
      ed = 1'b0;
    end
  endtask

  // One full transaction. Latency counts edges, and the accept edge counts as edge 1.
  task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] ya,
                       input int stall, input bit noise);
    logic [W-1:0] eq, er;
    logic         ed;
    int           edges;
    model(xa, ya, eq, er, ed);
    @(negedge clk);
    in_valid  = 1'b1;
    x         = xa;
    y         = ya;
    out_ready = 1'b0;
    check("in_ready_idle", in_ready, 1);
    @(posedge clk); #1;
    edges = 1;
    check("in_ready_after_accept", in_ready, 0);
    if (!noise) in_valid = 1'b0;
    while (!out_valid && edges < 20) begin
      @(negedge clk);
      if (noise) begin
        x = W'($urandom);
        y = W'($urandom);
      end
      @(posedge clk); #1;
      edges++;
    end
    check("latency", edges, (ya == 0) ? 1 : W + 1);
    check("quotient", quotient, eq);
    check("remainder", remainder, er);
    check("div_by_zero", div_by_zero, ed);
    check("busy_done", busy, 1);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1);
      check("hold_quotient", quotient, eq);
      check("hold_remainder", remainder, er);
      check("hold_in_ready", in_ready, 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("valid_drop", out_valid, 0);
    check("in_ready_back", in_ready, 1);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b1;   // reset must win over a same-cycle request
    out_ready = 1'b0;
    x         = 4'd5;
    y         = 4'd2;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_dbz", div_by_zero, 0);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;

    // Directed cases
    do_op(4'd13, 4'd4, 0, 1'b0);
    do_op(4'd7,  4'd0, 0, 1'b0);
    do_op(4'd9,  4'd3, 0, 1'b0);
    do_op(4'd15, 4'd1, 10, 1'b0);
    do_op(4'd0,  4'd5, 0, 1'b0);

    // Reset in the middle of an operation
    @(negedge clk);
    in_valid = 1'b1;
    x        = 4'd14;
    y        = 4'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_quotient", quotient, 0);
    check("midrst_remainder", remainder, 0);
    check("midrst_dbz", div_by_zero, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("midrst_no_result", out_valid, 0);
    end
    do_op(4'd14, 4'd3, 0, 1'b0);

`ifdef DIV_SEQ_SIGNED_EN
    do_op(4'b1001, 4'd2,    0, 1'b0);
    do_op(4'b1000, 4'b1111, 0, 1'b0);
`endif

    // Exhaustive sweep with random back-pressure and in_valid noise
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        do_op(W'(a), W'(b), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
